pc_fetch_ctrl: RTL and testbench

//  Fetch-stage PC generator and instruction-memory requester; sits upstream of decode and consumes the EX-stage branch-unit redirect (is_taken, pc_bru).

---
 rtl/pc_fetch_ctrl.sv | 90 +++++++++
 tb/tb_pc_fetch_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch-stage PC generator with a single-request imem port, 1-entry skid buffer and branch redirect.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_taken,
  input  logic [31:0] pc_bru,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        flush,
  output logic        misalign
);
  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, drain_addr_q, drain_addr_d;
  logic [31:0] if_pc_q, if_pc_d, if_instr_q, if_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d, skid_instr_q, skid_instr_d;
  logic        if_valid_q, if_valid_d, skid_valid_q, skid_valid_d, misalign_q, misalign_d;
  logic        fetch_ack, to_out, to_skid, from_skid, busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      misalign_q   <= misalign_d;
    end
  end

  // A redirect with a request still in flight must drain that response before refetching.
  always_comb begin
    busy    = state_q == FETCH || state_q == DRAIN;
    state_d = is_taken ? (busy && !imem_ack ? DRAIN : FETCH) :
              state_q == BOOT  ? FETCH :
              state_q == FETCH ? (imem_ack && if_valid_q && stall ? HOLD : FETCH) :
              state_q == HOLD  ? (stall ? HOLD : FETCH) :
              (imem_ack ? FETCH : DRAIN);
  end

  always_comb begin
    fetch_ack    = state_q == FETCH && imem_ack;
    to_out       = fetch_ack && (!if_valid_q || !stall);
    to_skid      = fetch_ack && if_valid_q && stall;
    from_skid    = state_q == HOLD && skid_valid_q && !stall;
    pc_d         = is_taken ? {pc_bru[31:2], 2'b00} : fetch_ack ? pc_q + 32'd4 : pc_q;
    drain_addr_d = is_taken && state_q == FETCH ? pc_q : drain_addr_q;
    if_valid_d   = is_taken ? 1'b0 : (to_out || from_skid) ? 1'b1 : stall && if_valid_q;
    if_pc_d      = is_taken ? if_pc_q : to_out ? pc_q : from_skid ? skid_pc_q : if_pc_q;
    if_instr_d   = is_taken ? NOP_INSTR : to_out ? imem_rdata : from_skid ? skid_instr_q : if_instr_q;
    skid_valid_d = is_taken ? 1'b0 : to_skid ? 1'b1 : from_skid ? 1'b0 : skid_valid_q;
    skid_pc_d    = to_skid ? pc_q : skid_pc_q;
    skid_instr_d = to_skid ? imem_rdata : skid_instr_q;
    misalign_d   = is_taken && |pc_bru[1:0];
  end

  always_comb begin
    imem_req  = state_q == FETCH || state_q == DRAIN;
    imem_addr = state_q == DRAIN ? drain_addr_q : pc_q;
    if_valid  = if_valid_q;
    if_pc     = if_pc_q;
    if_instr  = if_instr_q;
    flush     = is_taken;
    misalign  = misalign_q;
  end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed vector table plus hand sequences for redirect-from-HOLD and boot latency.
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0, rst, is_taken, stall, imem_ack, imem_req, if_valid, flush, misalign;
  logic [31:0] pc_bru, imem_rdata, imem_addr, if_pc, if_instr;
  int          total = 0, passed = 0;

  typedef struct {
    logic        rst, tk;
    logic [31:0] bru;
    logic        st, ack;
    logic [31:0] rd;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc, ins;
    logic        fl, mis;
  } vec_t;

  vec_t tbl[26];

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst), .is_taken(is_taken), .pc_bru(pc_bru), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .flush(flush), .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic t, logic [31:0] b, logic s, logic a, logic [31:0] d,
                              logic q, logic [31:0] ad, logic v, logic [31:0] p, logic [31:0] i,
                              logic f, logic m);
    vec_t x;
    x.rst = r; x.tk = t; x.bru = b; x.st = s; x.ack = a; x.rd = d;
    x.req = q; x.addr = ad; x.v = v; x.pc = p; x.ins = i; x.fl = f; x.mis = m;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic drv(input logic r, input logic t, input logic [31:0] b, input logic s,
                     input logic a, input logic [31:0] d);
    rst = r; is_taken = t; pc_bru = b; stall = s; imem_ack = a; imem_rdata = d;
  endtask

  initial begin
    //            rst tk bru           st ack rd            req addr          v  pc            instr         fl mis
    tbl[0]  = mk(1, 0, 0,            0, 0, 0,            0, 32'h0,        0, 32'h0,        32'h13,       0, 0);
    tbl[1]  = mk(0, 0, 0,            0, 0, 0,            0, 32'h0,        0, 32'h0,        32'h13,       0, 0);
    tbl[2]  = mk(0, 0, 0,            0, 1, 32'hA0,       1, 32'h0,        0, 32'h0,        32'h13,       0, 0);
    tbl[3]  = mk(0, 0, 0,            0, 1, 32'hA4,       1, 32'h4,        1, 32'h0,        32'hA0,       0, 0);
    tbl[4]  = mk(0, 0, 0,            1, 1, 32'hA8,       1, 32'h8,        1, 32'h4,        32'hA4,       0, 0);
    tbl[5]  = mk(0, 0, 0,            1, 0, 0,            0, 32'hC,        1, 32'h4,        32'hA4,       0, 0);
    tbl[6]  = mk(0, 0, 0,            0, 0, 0,            0, 32'hC,        1, 32'h4,        32'hA4,       0, 0);
    tbl[7]  = mk(0, 0, 0,            0, 0, 0,            1, 32'hC,        1, 32'h8,        32'hA8,       0, 0);
    tbl[8]  = mk(0, 0, 0,            0, 0, 0,            1, 32'hC,        0, 32'h8,        32'hA8,       0, 0);
    tbl[9]  = mk(0, 0, 0,            0, 1, 32'hAC,       1, 32'hC,        0, 32'h8,        32'hA8,       0, 0);
    tbl[10] = mk(0, 1, 32'h200,      0, 0, 0,            1, 32'h10,       1, 32'hC,        32'hAC,       1, 0);
    tbl[11] = mk(0, 0, 0,            0, 0, 0,            1, 32'h10,       0, 32'hC,        32'h13,       0, 0);
    tbl[12] = mk(0, 0, 0,            0, 1, 32'hDEAD,     1, 32'h10,       0, 32'hC,        32'h13,       0, 0);
    tbl[13] = mk(0, 0, 0,            0, 1, 32'hB0,       1, 32'h200,      0, 32'hC,        32'h13,       0, 0);
    tbl[14] = mk(0, 1, 32'h20,       0, 1, 32'hB4,       1, 32'h204,      1, 32'h200,      32'hB0,       1, 0);
    tbl[15] = mk(0, 1, 32'h80,       0, 1, 32'hC0,       1, 32'h20,       0, 32'h200,      32'h13,       1, 0);
    tbl[16] = mk(0, 0, 0,            0, 1, 32'hC4,       1, 32'h80,       0, 32'h200,      32'h13,       0, 0);
    tbl[17] = mk(0, 1, 32'hFFFFFFFC, 0, 0, 0,            1, 32'h84,       1, 32'h80,       32'hC4,       1, 0);
    tbl[18] = mk(0, 1, 32'h102,      0, 0, 0,            1, 32'h84,       0, 32'h80,       32'h13,       1, 0);
    tbl[19] = mk(0, 0, 0,            0, 1, 32'hBAD,      1, 32'h84,       0, 32'h80,       32'h13,       0, 1);
    tbl[20] = mk(0, 0, 0,            0, 1, 32'hD0,       1, 32'h100,      0, 32'h80,       32'h13,       0, 0);
    tbl[21] = mk(0, 1, 32'hFFFFFFFC, 0, 1, 32'hD4,       1, 32'h104,      1, 32'h100,      32'hD0,       1, 0);
    tbl[22] = mk(0, 0, 0,            0, 1, 32'hE0,       1, 32'hFFFFFFFC, 0, 32'h100,      32'h13,       0, 0);
    tbl[23] = mk(0, 0, 0,            1, 0, 0,            1, 32'h0,        1, 32'hFFFFFFFC, 32'hE0,       0, 0);
    tbl[24] = mk(1, 0, 0,            1, 1, 32'hE4,       1, 32'h0,        1, 32'hFFFFFFFC, 32'hE0,       0, 0);
    tbl[25] = mk(0, 0, 0,            0, 0, 0,            0, 32'h0,        0, 32'h0,        32'h13,       0, 0);

    drv(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drv(tbl[i].rst, tbl[i].tk, tbl[i].bru, tbl[i].st, tbl[i].ack, tbl[i].rd);
      #1;
      chk($sformatf("v%0d.req", i),   {31'b0, imem_req}, {31'b0, tbl[i].req});
      chk($sformatf("v%0d.addr", i),  imem_addr,         tbl[i].addr);
      chk($sformatf("v%0d.valid", i), {31'b0, if_valid}, {31'b0, tbl[i].v});
      chk($sformatf("v%0d.pc", i),    if_pc,             tbl[i].pc);
      chk($sformatf("v%0d.instr", i), if_instr,          tbl[i].ins);
      chk($sformatf("v%0d.flush", i), {31'b0, flush},    {31'b0, tbl[i].fl});
      chk($sformatf("v%0d.mis", i),   {31'b0, misalign}, {31'b0, tbl[i].mis});
    end

    // Redirect while a word sits in the skid buffer: the skid word must never reach decode.
    @(negedge clk); drv(0, 0, 0, 1, 1, 32'hF0); #1;
    chk("h.req0", imem_addr, 32'h0);
    @(negedge clk); drv(0, 0, 0, 1, 1, 32'hF4); #1;
    chk("h.pc0", if_pc, 32'h0);
    @(negedge clk); drv(0, 1, 32'h300, 1, 0, 0); #1;
    chk("h.hold_req", {31'b0, imem_req}, 32'h0);
    chk("h.hold_pc", if_pc, 32'h0);
    @(negedge clk); drv(0, 0, 0, 0, 1, 32'hF8); #1;
    chk("h.tgt_addr", imem_addr, 32'h300);
    chk("h.tgt_valid", {31'b0, if_valid}, 32'h0);
    chk("h.tgt_instr", if_instr, 32'h13);
    @(negedge clk); drv(0, 0, 0, 0, 0, 0); #1;
    chk("h.tgt_pc", if_pc, 32'h300);
    chk("h.tgt_data", if_instr, 32'hF8);

    // Boot latency: exactly one idle cycle after reset, bounded wait.
    @(negedge clk); drv(1, 0, 0, 0, 0, 0);
    @(negedge clk); drv(0, 0, 0, 0, 0, 0);
    begin
      int n = 0;
      #1;
      while (!imem_req && n < 5) begin
        @(negedge clk); #1; n++;
      end
      chk("boot.latency", n, 1);
      chk("boot.addr", imem_addr, 32'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
